// File: rtl/fpu_link_host.sv
// Host end of the FPU pin link: sends (a, b, op) as four 9-bit beats on the chip
// input bus, then gathers the two-byte result (or a timeout) for the consumer.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request handshake
// SEND  | request beats on bus_out, GAP idle cycles between beats
// WAIT  | waiting for result low byte (idx 0)
// RECV  | low byte held, waiting for high byte (idx 1); idx 0 resyncs
// DONE  | result or timeout presented until res_ready
module fpu_link_host #(
  parameter int GAP     = 0,
  parameter int TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [3:0]  req_op,
  output logic [11:0] bus_out,
  input  logic [11:0] bus_in,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_y,
  output logic        res_timeout
);

  // timeout timer is a down-counter loaded with TIMEOUT-1; expiry when it reads zero
  localparam int TW = (TIMEOUT < 3) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);
  localparam logic [3:0]    GAP_LOAD = 4'(GAP);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_RECV, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [15:0]    a_q, a_d, b_q, b_d;
  logic [3:0]     op_q, op_d;
  logic [1:0]     beat_q, beat_d;
  logic [3:0]     gap_q, gap_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [11:0]    bus_d;
  logic           req_ready_d, res_valid_d, res_timeout_d;
  logic [15:0]    res_y_d;

  logic           handshake, lo_hit, hi_hit, tmo_hit;
  logic [7:0]     in_byte;
  logic           unused_bits;

  assign handshake   = req_valid && req_ready;
  assign lo_hit      = bus_in[11] && !bus_in[10];
  assign hi_hit      = bus_in[11] &&  bus_in[10];
  assign in_byte     = bus_in[7:0];
  assign tmo_hit     = (tmo_q == '0);
  assign unused_bits = ^bus_in[9:8];

  function automatic logic [11:0] beat_word(input logic [1:0]  k,
                                            input logic [15:0] a,
                                            input logic [15:0] b,
                                            input logic [3:0]  op);
    logic [8:0] p;
    case (k)
      2'd0:    p = a[8:0];
      2'd1:    p = {b[1:0], a[15:9]};
      2'd2:    p = b[10:2];
      default: p = {op, b[15:11]};
    endcase
    return {1'b1, k, p};
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (handshake) state_d = S_SEND;
      S_SEND: if (beat_q == 2'd3) state_d = S_WAIT;
      S_WAIT: begin
        if (lo_hit)       state_d = S_RECV;
        else if (tmo_hit) state_d = S_DONE;
      end
      S_RECV: begin
        if (hi_hit)                  state_d = S_DONE;
        else if (!lo_hit && tmo_hit) state_d = S_DONE;
      end
      S_DONE: if (res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    a_d           = a_q;
    b_d           = b_q;
    op_d          = op_q;
    beat_d        = beat_q;
    gap_d         = gap_q;
    tmo_d         = tmo_q;
    bus_d         = '0;
    res_valid_d   = res_valid;
    res_y_d       = res_y;
    res_timeout_d = res_timeout;
    case (state_q)
      S_IDLE: begin
        if (handshake) begin
          a_d    = req_a;
          b_d    = req_b;
          op_d   = req_op;
          beat_d = 2'd0;
          gap_d  = GAP_LOAD;
          bus_d  = beat_word(2'd0, req_a, req_b, req_op);
        end
      end
      S_SEND: begin
        if (beat_q == 2'd3) begin
          tmo_d = TMO_LOAD;
        end else if (gap_q == 4'd0) begin
          beat_d = beat_q + 2'd1;
          gap_d  = GAP_LOAD;
          bus_d  = beat_word(beat_q + 2'd1, a_q, b_q, op_q);
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      S_WAIT, S_RECV: begin
        // an accepted beat takes priority over an expiring timer
        if (hi_hit && state_q == S_RECV) begin
          res_y_d[15:8] = in_byte;
          res_valid_d   = 1'b1;
          res_timeout_d = 1'b0;
        end else if (lo_hit) begin
          res_y_d[7:0] = in_byte;
          tmo_d        = TMO_LOAD;
        end else if (tmo_hit) begin
          res_y_d       = '0;
          res_valid_d   = 1'b1;
          res_timeout_d = 1'b1;
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
      end
      S_DONE: if (res_ready) res_valid_d = 1'b0;
      default: ;
    endcase
    req_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      beat_q      <= '0;
      gap_q       <= '0;
      tmo_q       <= '0;
      bus_out     <= '0;
      req_ready   <= 1'b1;
      res_valid   <= 1'b0;
      res_y       <= '0;
      res_timeout <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      beat_q      <= beat_d;
      gap_q       <= gap_d;
      tmo_q       <= tmo_d;
      bus_out     <= bus_d;
      req_ready   <= req_ready_d;
      res_valid   <= res_valid_d;
      res_y       <= res_y_d;
      res_timeout <= res_timeout_d;
    end
  end

endmodule
